multiplier_arbiter: RTL and testbench
=====================================

// Module: multiplier_arbiter
// PURPOSE
//  Round-robin arbiter sharing one sequential float multiplier among N_REQ requesters.
//  Accepts an (a,b) operand pair from one requester and drives it into the multiplier's
//  a/b stb-ack ports. Collects the result z and returns it on the winner's response channel.
//  One operation in flight. Sits between client engines and the multiplier instance.
// PARAMETERS
//  N_REQ   4   number of requesters (2..16)
//  ID_W    2   width of grant index, = clog2(N_REQ)
// PORTS
//  clk          in   1         clock; all logic on rising edge
//  rst          in   1         asynchronous, active-low reset
//  req_a        in   32*N_REQ  operand a per requester; slice i = [32*i+31:32*i]
//  req_b        in   32*N_REQ  operand b per requester
//  req_stb      in   N_REQ     requester i has an operand pair valid
//  req_ack      out  N_REQ     operand pair accepted (one-hot, registered)
//  resp_z       out  32        result for the granted requester
//  resp_stb     out  N_REQ     result valid for requester i (one-hot, registered)
//  resp_ack     in   N_REQ     requester i takes the result
//  mul_a        out  32        to multiplier input_a
//  mul_a_stb    out  1         to multiplier input_a_stb
//  mul_a_ack    in   1         from multiplier input_a_ack
//  mul_b        out  32        to multiplier input_b
//  mul_b_stb    out  1         to multiplier input_b_stb
//  mul_b_ack    in   1         from multiplier input_b_ack
//  mul_z        in   32        from multiplier output_z
//  mul_z_stb    in   1         from multiplier output_z_stb
//  mul_z_ack    out  1         to multiplier output_z_ack
//  grant_id     out  ID_W      index of current or last granted requester
//  busy         out  1         high in every state except IDLE
//  ops_done     out  16        completed operations; wraps 0xFFFF->0
// BEHAVIOUR
//  Handshake: a transfer occurs on a rising edge where stb and ack are both high.
//  The stb side holds data stable until that edge.
//  Reset (rst=0): state=IDLE. All stb/ack outputs=0. resp_z, mul_a, mul_b=0.
//  grant_id=0. ops_done=0. last_grant=N_REQ-1, so requester 0 has first priority.
//  Reset mid-operation abandons the op with no response. Top level must reset the
//  multiplier in the same window.
//  FSM:
//   IDLE:    if any req_stb: g = first set bit scanning last_grant+1, +2, ... mod N_REQ.
//            grant_id<=g; req_ack[g]<=1; ->ACCEPT.
//   ACCEPT:  if req_stb[g]: latch op_a/op_b from slice g; req_ack<=0; ->SEND_A.
//            else (request withdrawn): req_ack<=0; ->IDLE; last_grant unchanged.
//   SEND_A:  mul_a_stb=1, mul_a=op_a; on transfer: mul_a_stb<=0; ->SEND_B.
//   SEND_B:  mul_b_stb=1, mul_b=op_b; on transfer: mul_b_stb<=0; ->WAIT_Z.
//   WAIT_Z:  mul_z_ack=1; on transfer: resp_z<=mul_z; mul_z_ack<=0; ->RETURN.
//   RETURN:  resp_stb[g]=1; on resp_ack[g]: resp_stb<=0; last_grant<=g;
//            ops_done<=ops_done+1; ->IDLE.
//  Arbiter overhead: 2 cycles request-to-ack (IDLE, ACCEPT), plus 1 cycle back to IDLE.
//  Total latency = overhead + multiplier latency.
//  Non-granted req_stb lines are ignored until IDLE; their req_ack stays 0.
//  New requests arriving during an op wait. Round-robin rotation makes starvation impossible.
//  resp_ack on a non-granted line is ignored. resp_z holds its value until the next result.
//  The multiplier may assert mul_a_ack/mul_b_ack early. Only the transfer edge matters.
// TESTING
//  1. Single op: req0 a=0x40000000 (2.0), b=0x40400000 (3.0) ->
//     resp_stb[0], resp_z=0x40C00000; ops_done=1.
//  2. All 4 req_stb held high from reset -> grant order 0,1,2,3,0.
//     Each resp_stb[i] is one-hot and matches its own operands.
//  3. req1 (0xBF800000 x 0x40800000) with resp_ack[1] held low 20 cycles ->
//     resp_z=0xC0800000 held stable; no new grant until ack.
//  4. Withdraw req2 in ACCEPT (req_stb[2]=0) -> back to IDLE, no mul_a_stb, ops_done unchanged.
//     A later req2 is still granted next.
//  5. rst=0 asserted during WAIT_Z -> all stb/ack outputs 0 immediately.
//     After release, req0 0x3FC00000 x 0x40000000 -> 0x40400000.
//  6. Wrap: preload ops_done via force to 0xFFFF, complete one op -> ops_done=0.

Source files
------------

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter that time-shares one stb/ack float multiplier among N_REQ clients.
// One operation is in flight at a time; the result returns on the winner's response channel.
`timescale 1ns/1ps
module multiplier_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  input  logic [N_REQ-1:0]      req_stb,
  output logic [N_REQ-1:0]      req_ack,
  output logic [31:0]           resp_z,
  output logic [N_REQ-1:0]      resp_stb,
  input  logic [N_REQ-1:0]      resp_ack,
  output logic [31:0]           mul_a,
  output logic                  mul_a_stb,
  input  logic                  mul_a_ack,
  output logic [31:0]           mul_b,
  output logic                  mul_b_stb,
  input  logic                  mul_b_ack,
  input  logic [31:0]           mul_z,
  input  logic                  mul_z_stb,
  output logic                  mul_z_ack,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy,
  output logic [15:0]           ops_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_SEND_A,
    S_SEND_B,
    S_WAIT_Z,
    S_RETURN
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_grant;
  logic [ID_W-1:0]   w_grant_next;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   w_rr_pick;
  logic [ID_W-1:0]   w_rr_idx;
  logic              w_rr_found;
  logic [N_REQ-1:0]  w_onehot_next;
  logic [N_REQ-1:0]  w_onehot_cur;
  logic [31:0]       w_slice_a [N_REQ];
  logic [31:0]       w_slice_b [N_REQ];

  logic [N_REQ-1:0]  r_req_ack;
  logic [N_REQ-1:0]  r_resp_stb;
  logic [31:0]       r_resp_z;
  logic [31:0]       r_op_a;
  logic [31:0]       r_op_b;
  logic              r_mul_a_stb;
  logic              r_mul_b_stb;
  logic              r_mul_z_ack;
  logic [15:0]       r_ops_done;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign w_slice_a[gi] = req_a[32*gi +: 32];
    assign w_slice_b[gi] = req_b[32*gi +: 32];
  end

  // Scan starts just after the last completed grant, so every client gets a turn.
  always_comb begin
    w_rr_pick  = r_last_grant;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_rr_idx = ID_W'((int'(r_last_grant) + k) % N_REQ);
      if (!w_rr_found && req_stb[w_rr_idx]) begin
        w_rr_pick  = w_rr_idx;
        w_rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    case (r_state)
      S_IDLE: begin
        if (|req_stb) begin
          w_grant_next = w_rr_pick;
          w_state_next = S_ACCEPT;
        end
      end
      S_ACCEPT: w_state_next = req_stb[r_grant] ? S_SEND_A : S_IDLE;
      S_SEND_A: if (mul_a_ack) w_state_next = S_SEND_B;
      S_SEND_B: if (mul_b_ack) w_state_next = S_WAIT_Z;
      S_WAIT_Z: if (mul_z_stb) w_state_next = S_RETURN;
      S_RETURN: if (resp_ack[r_grant]) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  assign w_onehot_next = {{(N_REQ-1){1'b0}}, 1'b1} << w_grant_next;
  assign w_onehot_cur  = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;

  // Handshake outputs are registered from the next state so each is high for exactly its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_req_ack    <= '0;
      r_resp_stb   <= '0;
      r_resp_z     <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_mul_a_stb  <= 1'b0;
      r_mul_b_stb  <= 1'b0;
      r_mul_z_ack  <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_req_ack   <= (w_state_next == S_ACCEPT) ? w_onehot_next : '0;
      r_mul_a_stb <= (w_state_next == S_SEND_A);
      r_mul_b_stb <= (w_state_next == S_SEND_B);
      r_mul_z_ack <= (w_state_next == S_WAIT_Z);
      r_resp_stb  <= (w_state_next == S_RETURN) ? w_onehot_cur : '0;
      if (r_state == S_ACCEPT && req_stb[r_grant]) begin
        r_op_a <= w_slice_a[r_grant];
        r_op_b <= w_slice_b[r_grant];
      end
      if (r_state == S_WAIT_Z && mul_z_stb) begin
        r_resp_z <= mul_z;
      end
      if (r_state == S_RETURN && resp_ack[r_grant]) begin
        r_last_grant <= r_grant;
        r_ops_done   <= r_ops_done + 16'd1;
      end
    end
  end

  assign req_ack   = r_req_ack;
  assign resp_stb  = r_resp_stb;
  assign resp_z    = r_resp_z;
  assign mul_a     = r_op_a;
  assign mul_b     = r_op_b;
  assign mul_a_stb = r_mul_a_stb;
  assign mul_b_stb = r_mul_b_stb;
  assign mul_z_ack = r_mul_z_ack;
  assign grant_id  = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Scoreboard bench for multiplier_arbiter: queued clients, a randomized stb/ack multiplier,
// and a round-robin reference that predicts the service order of each batch.
`timescale 1ns/1ps
module tb_multiplier_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]    req_stb = '0;
  logic [N-1:0]    req_ack;
  logic [31:0]     resp_z;
  logic [N-1:0]    resp_stb;
  logic [N-1:0]    resp_ack = '0;
  logic [31:0]     mul_a, mul_b;
  logic            mul_a_stb, mul_b_stb, mul_z_ack;
  logic            mul_a_ack = 1'b0;
  logic            mul_b_ack = 1'b0;
  logic [31:0]     mul_z = '0;
  logic            mul_z_stb = 1'b0;
  logic [IDW-1:0]  grant_id;
  logic            busy;
  logic [15:0]     ops_done;

  multiplier_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .resp_z(resp_z), .resp_stb(resp_stb), .resp_ack(resp_ack),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .grant_id(grant_id), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [31:0] z; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; } mop_t;

  exp_t        sb[$];
  mop_t        mq[$];
  logic [31:0] qa [N][$];
  logic [31:0] qb [N][$];
  logic [31:0] stage_a [N][$];
  logic [31:0] stage_b [N][$];
  bit [N-1:0]  wd = '0;

  int          total = 0;
  int          bad = 0;
  int          model_last = N - 1;
  logic [15:0] model_ops = '0;
  int          n_a_stb = 0;
  bit          z_hold = 1'b0;
  bit          hold_en = 1'b0;
  logic [31:0] last_z = '0;
  int          last_id = -1;

  bit          have_a = 1'b0, have_b = 1'b0, z_busy = 1'b0, z_xfer = 1'b0;
  int          zdly = 0;
  logic [31:0] cap_a = '0, cap_b = '0, zval = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Truncating single-precision multiply, valid for normal operands.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int e;
    logic [47:0] p;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e++; end
    else m = p[45:23];
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], m};
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic add_op(input int i, input logic [31:0] a, input logic [31:0] b);
    stage_a[i].push_back(a);
    stage_b[i].push_back(b);
  endtask

  // Reference: serve the staged batch in round-robin order after the last completed grant.
  task automatic commit();
    int idx[N];
    int left;
    int last;
    bit found;
    left = 0;
    for (int i = 0; i < N; i++) begin idx[i] = 0; left += stage_a[i].size(); end
    last = model_last;
    while (left > 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (!found && idx[j] < stage_a[j].size()) begin
          exp_t e;
          e.id = j;
          e.a  = stage_a[j][idx[j]];
          e.b  = stage_b[j][idx[j]];
          e.z  = fmul(e.a, e.b);
          sb.push_back(e);
          idx[j]++;
          last = j;
          left--;
          found = 1'b1;
        end
      end
    end
    model_last = last;
    for (int i = 0; i < N; i++) begin
      foreach (stage_a[i][k]) begin qa[i].push_back(stage_a[i][k]); qb[i].push_back(stage_b[i][k]); end
      stage_a[i].delete();
      stage_b[i].delete();
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL %s_timeout: outstanding=%0d busy=%0b required outstanding=0 busy=0", name, sb.size(), busy);
    end
    @(negedge clk);
    chk({name, "_ops_done"}, 32'(ops_done), 32'(model_ops));
  endtask

  // Client driver: holds stb with the queue head until the accepting edge, or withdraws on ack.
  initial begin
    forever begin
      bit [N-1:0] acc;
      @(negedge clk);
      acc = req_ack & req_stb;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && wd[i]) begin
          req_stb[i] = 1'b0;
          qa[i].delete(0);
          qb[i].delete(0);
          wd[i] = 1'b0;
          acc[i] = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin qa[i].delete(0); qb[i].delete(0); end
        if (qa[i].size() > 0) begin
          req_a[32*i +: 32] = qa[i][0];
          req_b[32*i +: 32] = qb[i][0];
          req_stb[i] = 1'b1;
        end else begin
          req_stb[i] = 1'b0;
        end
      end
    end
  end

  // Multiplier model with random ack timing and random result latency.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_a = 1'b0; have_b = 1'b0; z_busy = 1'b0; z_xfer = 1'b0;
        mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0;
      end else begin
        if (z_xfer) begin mul_z_stb = 1'b0; z_xfer = 1'b0; end
        if (mul_a_stb) n_a_stb++;
        mul_a_ack = 1'($urandom_range(0, 1));
        mul_b_ack = 1'($urandom_range(0, 1));
        if (mul_a_stb && mul_a_ack) begin cap_a = mul_a; have_a = 1'b1; end
        if (mul_b_stb && mul_b_ack) begin
          chk("a_before_b", 32'(have_a), 32'd1);
          cap_b = mul_b;
          have_b = 1'b1;
        end
        if (z_busy && !mul_z_stb) begin
          if (zdly > 0) zdly--;
          else if (!z_hold) begin mul_z_stb = 1'b1; mul_z = zval; end
        end
        if (have_a && have_b && !z_busy) begin
          mop_t m;
          m.a = cap_a; m.b = cap_b;
          mq.push_back(m);
          zval = fmul(cap_a, cap_b);
          zdly = $urandom_range(0, 4);
          z_busy = 1'b1; have_a = 1'b0; have_b = 1'b0;
        end
        if (!mul_z_stb) mul_z = $urandom;
        if (mul_z_stb && mul_z_ack) begin z_xfer = 1'b1; z_busy = 1'b0; end
      end
    end
  end

  // Response monitor: pops the scoreboard on every resp_stb and acknowledges it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && resp_stb != '0) begin
        exp_t e;
        mop_t m;
        int id;
        int dly;
        logic [31:0] z0;
        logic [N-1:0] s0;
        s0 = resp_stb;
        id = -1;
        for (int i = 0; i < N; i++) if (s0[i]) id = i;
        chk("resp_onehot", 32'($countones(s0)), 32'd1);
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected: got resp_stb=%b required no response", s0);
        end else begin
          e = sb.pop_front();
          chk("resp_id", 32'(id), 32'(e.id));
          chk("resp_z", resp_z, e.z);
          chk("grant_id", 32'(grant_id), 32'(e.id));
          if (mq.size() == 0) begin
            total++; bad++;
            $display("FAIL mul_ops: got no operand transfer required a=%h b=%h", e.a, e.b);
          end else begin
            m = mq.pop_front();
            chk("mul_a_seen", m.a, e.a);
            chk("mul_b_seen", m.b, e.b);
          end
          $display("txn req=%0d a=%h b=%h z=%h", id, e.a, e.b, resp_z);
        end
        last_z = resp_z;
        last_id = id;
        dly = (hold_en && id == 1) ? 20 : $urandom_range(0, 2);
        if (hold_en && id == 1) chk("t3_z", resp_z, 32'hC0800000);
        z0 = resp_z;
        for (int c = 0; c < dly; c++) begin
          resp_ack = N'($urandom) & ~s0;
          @(negedge clk);
          chk("hold_stb", 32'(resp_stb), 32'(s0));
          chk("hold_z", resp_z, z0);
          chk("hold_no_grant", 32'(req_ack), 32'd0);
        end
        resp_ack = s0 | (N'($urandom) & ~s0);
        @(negedge clk);
        resp_ack = '0;
        model_ops++;
        chk("resp_drop", 32'(resp_stb), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    int a0;
    // All four clients pending from reset, client 0 with a second op queued.
    add_op(0, rnd_f(), rnd_f());
    add_op(0, rnd_f(), rnd_f());
    add_op(1, rnd_f(), rnd_f());
    add_op(2, rnd_f(), rnd_f());
    add_op(3, rnd_f(), rnd_f());
    commit();
    repeat (3) @(negedge clk);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_resp_stb", 32'(resp_stb), 32'd0);
    chk("rst_mul_a_stb", 32'(mul_a_stb), 32'd0);
    chk("rst_mul_b_stb", 32'(mul_b_stb), 32'd0);
    chk("rst_mul_z_ack", 32'(mul_z_ack), 32'd0);
    chk("rst_resp_z", resp_z, 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    rst = 1'b1;
    drain("t2");

    hold_en = 1'b1;
    add_op(1, 32'hBF800000, 32'h40800000);
    add_op(3, rnd_f(), rnd_f());
    commit();
    drain("t3");
    hold_en = 1'b0;

    add_op(1, rnd_f(), rnd_f());
    commit();
    drain("t4_pre");
    a0 = n_a_stb;
    wd[2] = 1'b1;
    qa[2].push_back(rnd_f());
    qb[2].push_back(rnd_f());
    n = 0;
    while (wd[2] && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL t4_withdraw_timeout: got no req_ack[2] required one");
    end
    repeat (6) @(negedge clk);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_no_mul_a_stb", 32'(n_a_stb), 32'(a0));
    chk("t4_ops_done", 32'(ops_done), 32'(model_ops));
    add_op(0, rnd_f(), rnd_f());
    add_op(2, rnd_f(), rnd_f());
    add_op(3, rnd_f(), rnd_f());
    commit();
    drain("t4");

    for (int r = 0; r < 12; r++) begin
      int mask;
      mask = $urandom_range(1, 15);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          int k;
          k = $urandom_range(1, 2);
          for (int j = 0; j < k; j++) add_op(i, rnd_f(), rnd_f());
        end
      end
      commit();
      drain("rand");
    end

    z_hold = 1'b1;
    add_op(0, rnd_f(), rnd_f());
    commit();
    n = 0;
    while (!mul_z_ack && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL t5_wait_z_timeout: got mul_z_ack=0 required 1");
    end
    #2 rst = 1'b0;
    #1;
    chk("t5_req_ack", 32'(req_ack), 32'd0);
    chk("t5_resp_stb", 32'(resp_stb), 32'd0);
    chk("t5_mul_a_stb", 32'(mul_a_stb), 32'd0);
    chk("t5_mul_b_stb", 32'(mul_b_stb), 32'd0);
    chk("t5_mul_z_ack", 32'(mul_z_ack), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ops_done", 32'(ops_done), 32'd0);
    repeat (2) @(negedge clk);
    sb.delete();
    mq.delete();
    model_last = N - 1;
    model_ops = '0;
    z_hold = 1'b0;
    rst = 1'b1;
    add_op(0, 32'h3FC00000, 32'h40000000);
    commit();
    drain("t5");
    chk("t5_z", last_z, 32'h40400000);
    chk("t5_ops_after", 32'(ops_done), 32'd1);

    rst = 1'b0;
    model_last = N - 1;
    model_ops = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    add_op(0, 32'h40000000, 32'h40400000);
    commit();
    drain("t1");
    chk("t1_z", last_z, 32'h40C00000);
    chk("t1_id", 32'(last_id), 32'd0);
    chk("t1_ops", 32'(ops_done), 32'd1);

    @(negedge clk);
    force dut.r_ops_done = 16'hFFFF;
    @(negedge clk);
    release dut.r_ops_done;
    model_ops = 16'hFFFF;
    add_op(2, rnd_f(), rnd_f());
    commit();
    drain("t6");
    chk("t6_wrap", 32'(ops_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
